pe_wdb: RTL and testbench

PE_WDB -- requirements
Module: pe_wdb

---
 rtl/pe_wdb_pkg.sv | 16 +
 rtl/pe_sat_add.sv | 29 ++
 rtl/pe_wdb.sv | 140 ++++++++++++++
 tb/tb_pe_wdb.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_wdb_pkg.sv
// Shared parameter defaults and mode encoding for the weight/output-stationary PE.
package pe_wdb_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int PSUM_W_DEF   = 24;
    localparam int ROW_ID_W_DEF = 4;
    localparam int ADDR_W_DEF   = 9;
    localparam int VALID_W_DEF  = 1;
    localparam int SAT_EN_DEF   = 1;

    typedef enum logic {
        MODE_WS = 1'b0,
        MODE_OS = 1'b1
    } pe_mode_e;

endpackage

// File: rtl/pe_sat_add.sv
// Combinational PSUM_W-bit signed adder with one guard bit; clamps or wraps on overflow.
module pe_sat_add #(
    parameter int PSUM_W = 24,
    parameter bit SAT_EN = 1'b1
) (
    input  logic signed [PSUM_W-1:0] a,
    input  logic signed [PSUM_W-1:0] b,
    output logic signed [PSUM_W-1:0] sum,
    output logic                     ovf
);

    localparam logic [PSUM_W-1:0] SUM_MAX = {1'b0, {(PSUM_W-1){1'b1}}};
    localparam logic [PSUM_W-1:0] SUM_MIN = {1'b1, {(PSUM_W-1){1'b0}}};

    logic [PSUM_W:0] w_full;

    assign w_full = {a[PSUM_W-1], a} + {b[PSUM_W-1], b};
    // The guard bit disagreeing with the sign bit is exactly the out-of-range case.
    assign ovf    = w_full[PSUM_W] ^ w_full[PSUM_W-1];

    // NOTE: assign sum unconditionally first so no path through this block infers a latch.
    always_comb begin
        sum = w_full[PSUM_W-1:0];
        if (SAT_EN && ovf) begin
            sum = w_full[PSUM_W] ? SUM_MIN : SUM_MAX;
        end
    end

endmodule

// File: rtl/pe_wdb.sv
// Systolic PE with double-buffered weight: WS adds the product to the incoming psum,
// OS accumulates locally and drains onto the psum chain.
module pe_wdb
    import pe_wdb_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int PSUM_W   = PSUM_W_DEF,
    parameter int ROW_ID_W = ROW_ID_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int VALID_W  = VALID_W_DEF,
    parameter int SAT_EN   = SAT_EN_DEF
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic        [ROW_ID_W-1:0] Row_ID,
    input  logic signed [DATA_W-1:0]   Data_I_In,
    output logic signed [DATA_W-1:0]   Data_I_Out,
    input  logic signed [DATA_W-1:0]   Data_W_In,
    output logic signed [DATA_W-1:0]   Data_W_Out,
    input  logic                       EN_W_In,
    output logic                       EN_W_Out,
    input  logic                       Clr_W_In,
    output logic                       Clr_W_Out,
    input  logic                       Swap_In,
    output logic                       Swap_Out,
    input  logic        [ROW_ID_W-1:0] EN_ID_In,
    output logic        [ROW_ID_W-1:0] EN_ID_Out,
    input  logic                       Mode_In,
    output logic                       Mode_Out,
    input  logic                       Drain_In,
    output logic                       Drain_Out,
    input  logic signed [PSUM_W-1:0]   Psum_In,
    output logic signed [PSUM_W-1:0]   Psum_Out,
    input  logic        [ADDR_W-1:0]   Addr_P_In,
    output logic        [ADDR_W-1:0]   Addr_P_Out,
    input  logic        [VALID_W-1:0]  Valid_P_In,
    output logic        [VALID_W-1:0]  Valid_P_Out,
    output logic                       Ovf_Out
);

    logic signed [DATA_W-1:0]   r_w_sh;
    logic signed [DATA_W-1:0]   r_w_act;
    logic signed [PSUM_W-1:0]   r_acc;

    logic                       w_sel;
    logic                       w_valid;
    pe_mode_e                   w_mode;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [PSUM_W-1:0]   w_prod_ext;
    logic signed [PSUM_W-1:0]   w_ws_sum;
    logic                       w_ws_ovf;
    logic signed [PSUM_W-1:0]   w_os_sum;
    logic                       w_os_ovf;

    assign w_sel      = (EN_ID_In == Row_ID);
    assign w_valid    = Valid_P_In[0];
    assign w_mode     = pe_mode_e'(Mode_In);
    assign w_prod     = Data_I_In * r_w_act;
    assign w_prod_ext = PSUM_W'(w_prod);

    pe_sat_add #(
        .PSUM_W (PSUM_W),
        .SAT_EN (SAT_EN != 0)
    ) u_ws_add (
        .a   (Psum_In),
        .b   (w_prod_ext),
        .sum (w_ws_sum),
        .ovf (w_ws_ovf)
    );

    pe_sat_add #(
        .PSUM_W (PSUM_W),
        .SAT_EN (SAT_EN != 0)
    ) u_os_add (
        .a   (r_acc),
        .b   (w_prod_ext),
        .sum (w_os_sum),
        .ovf (w_os_ovf)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Data_I_Out  <= '0;
            Data_W_Out  <= '0;
            EN_W_Out    <= 1'b0;
            Clr_W_Out   <= 1'b0;
            Swap_Out    <= 1'b0;
            EN_ID_Out   <= '0;
            Mode_Out    <= 1'b0;
            Drain_Out   <= 1'b0;
            Addr_P_Out  <= '0;
            Valid_P_Out <= '0;
            Psum_Out    <= '0;
            Ovf_Out     <= 1'b0;
            r_w_sh      <= '0;
            r_w_act     <= '0;
            r_acc       <= '0;
        end else begin
            Data_I_Out  <= Data_I_In;
            Data_W_Out  <= Data_W_In;
            EN_W_Out    <= EN_W_In;
            Clr_W_Out   <= Clr_W_In;
            Swap_Out    <= Swap_In;
            EN_ID_Out   <= EN_ID_In;
            Mode_Out    <= Mode_In;
            Drain_Out   <= Drain_In;
            Addr_P_Out  <= Addr_P_In;
            Valid_P_Out <= Valid_P_In;

            if (w_sel && EN_W_In) begin
                r_w_sh <= Data_W_In;
            end else if (w_sel && Clr_W_In) begin
                r_w_sh <= '0;
            end
            // Swap picks up the shadow value from before any same-cycle load.
            if (Swap_In) begin
                r_w_act <= r_w_sh;
            end

            if (w_mode == MODE_OS) begin
                if (Drain_In) begin
                    Psum_Out <= r_acc;
                    Ovf_Out  <= 1'b0;
                    r_acc    <= w_valid ? w_prod_ext : '0;
                end else begin
                    Psum_Out <= Psum_In;
                    Ovf_Out  <= w_valid & w_os_ovf;
                    if (w_valid) begin
                        r_acc <= w_os_sum;
                    end
                end
            end else begin
                Psum_Out <= w_ws_sum;
                Ovf_Out  <= w_ws_ovf;
            end
        end
    end

endmodule

// File: tb/tb_pe_wdb.sv
// Scoreboard bench for pe_wdb: saturating and wrapping instances share stimulus and are
// compared against an arithmetic reference model every cycle.
module tb_pe_wdb;

    localparam longint PMAX = (longint'(1) <<< 23) - 1;
    localparam longint PMIN = -(longint'(1) <<< 23);
    localparam longint PMOD = longint'(1) <<< 24;

    logic               clk = 1'b0;
    logic               rst;
    logic        [3:0]  row_id = 4'd3;
    logic signed [7:0]  di, dw;
    logic               enw, clrw, swap, mode, drain;
    logic        [3:0]  enid;
    logic signed [23:0] psum_in;
    logic        [8:0]  addr;
    logic        [0:0]  valid;

    logic signed [7:0]  s_di, s_dw, w_di, w_dw;
    logic               s_enw, s_clrw, s_swap, s_mode, s_drain, s_ovf;
    logic               w_enw, w_clrw, w_swap, w_mode, w_drain, w_ovf;
    logic        [3:0]  s_enid, w_enid;
    logic signed [23:0] s_psum, w_psum;
    logic        [8:0]  s_addr, w_addr;
    logic        [0:0]  s_valid, w_valid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pe_wdb #(.SAT_EN(1)) dut_sat (
        .CLK(clk), .RST(rst), .Row_ID(row_id),
        .Data_I_In(di), .Data_I_Out(s_di), .Data_W_In(dw), .Data_W_Out(s_dw),
        .EN_W_In(enw), .EN_W_Out(s_enw), .Clr_W_In(clrw), .Clr_W_Out(s_clrw),
        .Swap_In(swap), .Swap_Out(s_swap), .EN_ID_In(enid), .EN_ID_Out(s_enid),
        .Mode_In(mode), .Mode_Out(s_mode), .Drain_In(drain), .Drain_Out(s_drain),
        .Psum_In(psum_in), .Psum_Out(s_psum), .Addr_P_In(addr), .Addr_P_Out(s_addr),
        .Valid_P_In(valid), .Valid_P_Out(s_valid), .Ovf_Out(s_ovf)
    );

    pe_wdb #(.SAT_EN(0)) dut_wrap (
        .CLK(clk), .RST(rst), .Row_ID(row_id),
        .Data_I_In(di), .Data_I_Out(w_di), .Data_W_In(dw), .Data_W_Out(w_dw),
        .EN_W_In(enw), .EN_W_Out(w_enw), .Clr_W_In(clrw), .Clr_W_Out(w_clrw),
        .Swap_In(swap), .Swap_Out(w_swap), .EN_ID_In(enid), .EN_ID_Out(w_enid),
        .Mode_In(mode), .Mode_Out(w_mode), .Drain_In(drain), .Drain_Out(w_drain),
        .Psum_In(psum_in), .Psum_Out(w_psum), .Addr_P_In(addr), .Addr_P_Out(w_addr),
        .Valid_P_In(valid), .Valid_P_Out(w_valid), .Ovf_Out(w_ovf)
    );

    typedef struct {
        int     di, dw, enw, clrw, swap, enid, mode, drain, addr, valid;
        longint psum_s, psum_w;
        int     ovf_s, ovf_w;
    } exp_t;

    exp_t   sb[$];
    longint m_wsh, m_wact, m_acc_s, m_acc_w;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic sat_add(input longint a, input longint b, input bit sat_en,
                           output longint r, output int o);
        longint s;
        s = a + b;
        o = (s > PMAX || s < PMIN) ? 1 : 0;
        if (o == 0)      r = s;
        else if (sat_en) r = (s > PMAX) ? PMAX : PMIN;
        else             r = (s > PMAX) ? s - PMOD : s + PMOD;
    endtask

    // Push the model's expectation for the current inputs, clock, then pop and compare.
    task automatic step();
        exp_t   e, g;
        longint p;
        e = '{default: 0};
        if (rst) begin
            m_wsh = 0; m_wact = 0; m_acc_s = 0; m_acc_w = 0;
        end else begin
            e.di = int'(di); e.dw = int'(dw); e.enw = int'(enw); e.clrw = int'(clrw);
            e.swap = int'(swap); e.enid = int'(enid); e.mode = int'(mode);
            e.drain = int'(drain); e.addr = int'(addr); e.valid = int'(valid);
            p = longint'(di) * m_wact;
            if (!mode) begin
                sat_add(longint'(psum_in), p, 1'b1, e.psum_s, e.ovf_s);
                sat_add(longint'(psum_in), p, 1'b0, e.psum_w, e.ovf_w);
            end else if (drain) begin
                e.psum_s = m_acc_s; e.psum_w = m_acc_w;
                m_acc_s = valid[0] ? p : 0;
                m_acc_w = valid[0] ? p : 0;
            end else begin
                e.psum_s = longint'(psum_in); e.psum_w = longint'(psum_in);
                if (valid[0]) begin
                    sat_add(m_acc_s, p, 1'b1, m_acc_s, e.ovf_s);
                    sat_add(m_acc_w, p, 1'b0, m_acc_w, e.ovf_w);
                end
            end
            if (swap) m_wact = m_wsh;
            if (enw && enid == row_id)       m_wsh = longint'(dw);
            else if (clrw && enid == row_id) m_wsh = 0;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        check("data_i",   s_di,    g.di);
        check("data_w",   s_dw,    g.dw);
        check("en_w",     s_enw,   g.enw);
        check("clr_w",    s_clrw,  g.clrw);
        check("swap",     s_swap,  g.swap);
        check("en_id",    s_enid,  g.enid);
        check("mode",     s_mode,  g.mode);
        check("drain",    s_drain, g.drain);
        check("addr",     s_addr,  g.addr);
        check("valid",    s_valid, g.valid);
        check("psum_sat", s_psum,  32'(g.psum_s));
        check("ovf_sat",  s_ovf,   g.ovf_s);
        check("psum_wrap", w_psum, 32'(g.psum_w));
        check("ovf_wrap", w_ovf,   g.ovf_w);
        check("wrap_addr", w_addr, g.addr);
        check("wrap_mode", w_mode, g.mode);
    endtask

    task automatic idle();
        enw = 0; clrw = 0; swap = 0; drain = 0; valid = 0; dw = 0; enid = 0; di = 0;
    endtask

    task automatic load_swap(input logic signed [7:0] w);
        idle(); enw = 1; enid = 4'd3; dw = w; step();
        idle(); swap = 1; step();
        idle();
    endtask

    initial begin
        rst = 1; mode = 0; psum_in = 24'sd1234; addr = 9'h1a5;
        idle(); di = 8'sd17; dw = -8'sd3; enw = 1; swap = 1; drain = 1; valid = 1; enid = 4'd3;
        step(); step();
        check("rst_psum", s_psum, 0);
        rst = 0;

        // Basic WS MAC: 100 + (-7 * 5) = 65
        load_swap(8'sd5);
        mode = 0; di = -8'sd7; psum_in = 24'sd100; step();
        check("ws_basic", s_psum, 65);
        check("ws_basic_ovf", s_ovf, 0);

        // Row-ID filtering and swap ordering
        idle(); psum_in = 0; enw = 1; enid = 4'd2; dw = 8'sd9; step();
        idle(); swap = 1; step();
        idle(); di = 1; step();
        check("wrong_id", s_psum, 5);
        idle(); enw = 1; enid = 4'd3; dw = 8'sd9; swap = 1; step();
        idle(); di = 1; step();
        check("swap_old", s_psum, 5);
        idle(); swap = 1; di = 1; step();
        idle(); di = 1; step();
        check("swap_new", s_psum, 9);

        // Clear, load-beats-clear, clear at another row
        idle(); clrw = 1; enid = 4'd3; step();
        idle(); swap = 1; step();
        idle(); di = 1; step();
        check("clear", s_psum, 0);
        idle(); clrw = 1; enw = 1; enid = 4'd3; dw = 8'sd4; step();
        idle(); swap = 1; step();
        idle(); di = 1; step();
        check("load_wins", s_psum, 4);
        idle(); clrw = 1; enid = 4'd1; step();
        idle(); swap = 1; step();
        idle(); di = 1; step();
        check("clear_other", s_psum, 4);

        // Range boundaries in WS
        load_swap(8'sd127);
        di = 8'sd127; psum_in = 24'sd8388607; step();
        check("ws_clamp_hi", s_psum, 8388607);
        check("ws_ovf_hi", s_ovf, 1);
        check("ws_wrap_hi", w_psum, -8372480);
        check("ws_wrap_ovf", w_ovf, 1);
        di = -8'sd1; psum_in = -24'sd8388608; step();
        check("ws_clamp_lo", s_psum, -8388608);
        di = 8'sd1; psum_in = 24'sd8388480; step();
        check("ws_edge_ok", s_ovf, 0);

        // OS accumulate and drain
        load_swap(8'sd2);
        mode = 1; psum_in = 24'sd77;
        repeat (4) begin idle(); di = 3; valid = 1; step(); end
        idle(); di = 3; valid = 1; drain = 1; step();
        check("os_drain", s_psum, 24);
        idle(); drain = 1; step();
        check("os_restart", s_psum, 6);
        idle(); di = 3; step();
        check("os_forward", s_psum, 77);

        // Mode change keeps ACC
        repeat (2) begin idle(); di = 3; valid = 1; step(); end
        mode = 0; psum_in = 0;
        repeat (2) begin idle(); di = 3; valid = 1; step(); end
        mode = 1; idle(); drain = 1; step();
        check("mode_keep_acc", s_psum, 12);

        // OS accumulator overflow
        load_swap(8'sd127);
        mode = 1;
        repeat (530) begin idle(); di = 8'sd127; valid = 1; step(); end
        idle(); drain = 1; step();
        check("os_clamp", s_psum, 8388607);

        // Reset in the middle of accumulation and load
        load_swap(8'sd2);
        mode = 1;
        repeat (3) begin idle(); di = 5; valid = 1; step(); end
        rst = 1; idle(); enw = 1; enid = 4'd3; dw = 8'sd50; swap = 1; drain = 1; valid = 1; di = 5;
        step();
        check("rst_mid_psum", s_psum, 0);
        check("rst_mid_mode", s_mode, 0);
        rst = 0; idle(); drain = 1; step();
        check("rst_acc", s_psum, 0);
        mode = 0; idle(); di = 5; psum_in = 0; step();
        check("rst_wact", s_psum, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst     = ($urandom_range(0, 63) == 0);
            di      = 8'($urandom);
            dw      = 8'($urandom);
            enw     = 1'($urandom);
            clrw    = 1'($urandom);
            swap    = ($urandom_range(0, 3) == 0);
            enid    = 4'($urandom_range(0, 4));
            mode    = 1'($urandom);
            drain   = ($urandom_range(0, 7) == 0);
            psum_in = 24'($urandom);
            addr    = 9'($urandom);
            valid   = 1'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
